// File: rtl/alu_issue_queue_pkg.sv
// Shared ALU control definitions: opcode encoding used between the issue queue and the ALU.
package pck_control;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    alu_nop = 5'd0,
    alu_add = 5'd1,
    alu_sub = 5'd2,
    alu_and = 5'd3,
    alu_or  = 5'd4,
    alu_xor = 5'd5,
    alu_sll = 5'd6,
    alu_srl = 5'd7
  } sel_alu_op_e;

endpackage

// File: rtl/alu_issue_queue_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is refused even if a pop happens that cycle.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU command front-end: buffers commands, issues one per cycle, tracks ALU latency and tags results.
module alu_issue_queue
  import pck_control::*;
#(
  parameter int BITS    = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [ALU_OP_W-1:0]        i_cmd_op,
  input  logic [BITS-1:0]            i_cmd_a,
  input  logic [BITS-1:0]            i_cmd_b,
  input  logic                       i_cmd_fwd_a,
  input  logic [TAG_W-1:0]           i_cmd_tag,
  output sel_alu_op_e                o_sel_op,
  output logic [BITS-1:0]            o_op_a,
  output logic [BITS-1:0]            o_op_b,
  input  logic [BITS-1:0]            i_alu_res,
  output logic                       o_res_valid,
  output logic [BITS-1:0]            o_res,
  output logic [TAG_W-1:0]           o_res_tag,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_busy
);

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [BITS-1:0]     a;
    logic [BITS-1:0]     b;
    logic                fwd_a;
    logic [TAG_W-1:0]    tag;
  } cmd_t;

  cmd_t        w_cmd_in;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_issue;
  logic        w_inflight;

  sel_alu_op_e      r_sel_op;
  logic [BITS-1:0]  r_op_a;
  logic [BITS-1:0]  r_op_b;
  logic             r_iss_vld;
  logic [TAG_W-1:0] r_iss_tag;
  logic [ALU_LAT-1:0] r_pipe_vld;
  logic [TAG_W-1:0] r_pipe_tag [ALU_LAT];
  logic             r_res_valid;
  logic [BITS-1:0]  r_res;
  logic [TAG_W-1:0] r_res_tag;
  logic [BITS-1:0]  r_last_res;

  assign w_cmd_in    = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b, fwd_a: i_cmd_fwd_a, tag: i_cmd_tag};
  assign o_cmd_ready = !i_rst && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  // The issue register stage counts as in flight: its command is on the ALU ports right now.
  assign w_inflight  = r_iss_vld || (|r_pipe_vld);
  assign w_issue     = !w_empty && !(w_head.fwd_a && w_inflight);
  assign o_busy      = !i_rst && (!w_empty || w_inflight);

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_data  (w_cmd_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  // Issue stage: drive the ALU ports, idling with a NOP and zero operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_op  <= alu_nop;
      r_op_a    <= {BITS{1'b0}};
      r_op_b    <= {BITS{1'b0}};
      r_iss_vld <= 1'b0;
      r_iss_tag <= {TAG_W{1'b0}};
    end else if (w_issue) begin
      r_sel_op  <= sel_alu_op_e'(w_head.op);
      r_op_a    <= w_head.fwd_a ? r_last_res : w_head.a;
      r_op_b    <= w_head.b;
      r_iss_vld <= 1'b1;
      r_iss_tag <= w_head.tag;
    end else begin
      r_sel_op  <= alu_nop;
      r_op_a    <= {BITS{1'b0}};
      r_op_b    <= {BITS{1'b0}};
      r_iss_vld <= 1'b0;
      r_iss_tag <= {TAG_W{1'b0}};
    end
  end

  // Latency tracker: the ALU result for a command appears ALU_LAT cycles after its ports update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_vld  <= {ALU_LAT{1'b0}};
      for (int i = 0; i < ALU_LAT; i++) r_pipe_tag[i] <= {TAG_W{1'b0}};
      r_res_valid <= 1'b0;
      r_res       <= {BITS{1'b0}};
      r_res_tag   <= {TAG_W{1'b0}};
      r_last_res  <= {BITS{1'b0}};
    end else begin
      r_pipe_vld[0] <= r_iss_vld;
      r_pipe_tag[0] <= r_iss_tag;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
      r_res_valid <= r_pipe_vld[ALU_LAT-1];
      if (r_pipe_vld[ALU_LAT-1]) begin
        r_res      <= i_alu_res;
        r_res_tag  <= r_pipe_tag[ALU_LAT-1];
        r_last_res <= i_alu_res;
      end else begin
        r_res      <= r_res;
        r_res_tag  <= r_res_tag;
        r_last_res <= r_last_res;
      end
    end
  end

  assign o_sel_op    = r_sel_op;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_res_valid = r_res_valid;
  assign o_res       = r_res;
  assign o_res_tag   = r_res_tag;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with an adder ALU model of fixed latency.
module tb_alu_issue_queue;

  localparam int BITS    = 8;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [4:0]       cmd_op = 5'd0;
  logic [BITS-1:0]  cmd_a = 8'd0;
  logic [BITS-1:0]  cmd_b = 8'd0;
  logic             cmd_fwd = 1'b0;
  logic [TAG_W-1:0] cmd_tag = 4'd0;
  logic [4:0]       sel_op;
  logic [BITS-1:0]  op_a;
  logic [BITS-1:0]  op_b;
  logic [BITS-1:0]  alu_res;
  logic             res_valid;
  logic [BITS-1:0]  res;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       count;
  logic             busy;

  typedef struct {
    logic [BITS-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t            sb_q [$];
  logic [BITS-1:0] model_last = 8'd0;
  logic [BITS-1:0] alu_pipe [ALU_LAT];
  int              n_cmp = 0;
  int              n_err = 0;
  int              refused = 0;
  bit              mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_queue #(.BITS(BITS), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .i_cmd_fwd_a(cmd_fwd), .i_cmd_tag(cmd_tag),
    .o_sel_op(sel_op), .o_op_a(op_a), .o_op_b(op_b),
    .i_alu_res(alu_res),
    .o_res_valid(res_valid), .o_res(res), .o_res_tag(res_tag),
    .o_count(count), .o_busy(busy)
  );

  // ALU model: sum of the operands, ALU_LAT cycles after the ports change.
  always @(posedge clk) begin
    alu_pipe[0] <= op_a + op_b;
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_res = alu_pipe[ALU_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop the scoreboard on every result; check ready/count relation each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_rule", {31'd0, cmd_ready}, {31'd0, (!rst && count < 3'(DEPTH))});
      chk("count_max", {31'd0, (count <= 3'(DEPTH))}, 32'd1);
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", {24'd0, res}, 32'hDEAD);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("res_value", {24'd0, res}, {24'd0, e.res});
          chk("res_tag", {28'd0, res_tag}, {28'd0, e.tag});
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic fwd, input logic [3:0] tag);
    logic rdy;
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_fwd = fwd; cmd_tag = tag;
    rdy = cmd_ready;
    @(posedge clk);
    while (!rdy && waited < 50) begin
      refused++;
      waited++;
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
    end
    chk("send_accept", {31'd0, rdy}, 32'd1);
    if (rdy) begin
      e.res = (fwd ? model_last : a) + b;
      e.tag = tag;
      model_last = e.res;
      sb_q.push_back(e);
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((busy || sb_q.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    // Test 1: reset held with valid asserted.
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_a = 8'h11; cmd_b = 8'h22;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_ready", {31'd0, cmd_ready}, 32'd0);
      chk("t1_sel_op", {27'd0, sel_op}, 32'd0);
      chk("t1_res_valid", {31'd0, res_valid}, 32'd0);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_count", {29'd0, count}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;

    // Test 2: single command latency.
    send(5'd1, 8'h10, 8'h05, 1'b0, 4'd3);
    @(negedge clk);
    chk("t2_not_issued_yet", {27'd0, sel_op}, 32'd0);
    @(negedge clk);
    chk("t2_issue_op", {27'd0, sel_op}, 32'd1);
    chk("t2_issue_a", {24'd0, op_a}, 32'h10);
    chk("t2_issue_b", {24'd0, op_b}, 32'h05);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_latency", lat, 32'd3);
    drain();

    // Test 3: back-to-back with wrap.
    send(5'd1, 8'hFF, 8'h02, 1'b0, 4'd1);
    send(5'd1, 8'h01, 8'h01, 1'b0, 4'd2);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    chk("t3_consecutive", {31'd0, res_valid}, 32'd1);
    drain();

    // Test 4: forward hazard.
    send(5'd1, 8'd3, 8'd4, 1'b0, 4'd5);
    send(5'd1, 8'd0, 8'd10, 1'b1, 4'd6);
    @(negedge clk);
    @(negedge clk);
    chk("t4_stalled_op", {27'd0, sel_op}, 32'd0);
    chk("t4_stalled_count", {29'd0, count}, 32'd1);
    seen = 0;
    while (sel_op == 5'd0 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("t4_fwd_a", {24'd0, op_a}, 32'd7);
    chk("t4_fwd_b", {24'd0, op_b}, 32'd10);
    drain();

    // Test 5: backpressure through a forward chain.
    refused = 0;
    send(5'd1, 8'd9, 8'd1, 1'b0, 4'd0);
    for (int i = 1; i < 6; i++) send(5'd2, 8'd0, 8'(i), 1'b1, 4'(i));
    chk("t5_backpressure", {31'd0, (refused > 0)}, 32'd1);
    drain();

    // Test 6: reset with two in flight and two queued.
    send(5'd1, 8'd1, 8'd2, 1'b0, 4'd7);
    send(5'd1, 8'd3, 8'd4, 1'b0, 4'd8);
    send(5'd1, 8'd0, 8'd5, 1'b1, 4'd9);
    send(5'd1, 8'd0, 8'd6, 1'b1, 4'd10);
    @(negedge clk);
    chk("t6_pre_count", {29'd0, count}, 32'd2);
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    sb_q.delete();
    model_last = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_count", {29'd0, count}, 32'd0);
    chk("t6_post_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("t6_no_flushed_result", seen, 32'd0);

    // Forward with no result since reset uses zero.
    send(5'd1, 8'd0, 8'h21, 1'b1, 4'd4);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      send(5'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
